instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer that drives the processor's instruction side: it holds a small program memory, presents instruction and immediate words on the processor's `DIN`, and asserts `Run`. It observes `Done` to advance through the program. It sits between a loader (testbench, UART, host) and the processor's `DIN`/`Run`/`Done` ports. It is the initiator for the `Run`/`Done` handshake that the processor responds to.

## Interface
- `ADDR_W`, default 5: program memory address width; depth is 2^ADDR_W words.
- `TIMEOUT`, default 7: maximum EXEC cycles allowed without `Done` before the sequencer aborts.
- `Clock` input 1: single clock; all state changes on the rising edge.
- `Resetn` input 1: reset, synchronous, active-low.
- `start` input 1: level sampled in IDLE or ERR; begins execution at address 0.
- `last_addr` input ADDR_W: address of the final program word; sampled at start.
- `wr_en` input 1: program memory write strobe.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input 16: write data.
- `Done` input 1: processor completion flag.
- `DIN` output 16: word presented to the processor.
- `Run` output 1: processor run request.
- `busy` output 1: high in ISSUE and EXEC.
- `pc` output ADDR_W: address of the current instruction word.
- `instr_count` output 8: instructions completed since start; wraps at 255→0.
- `error` output 1: sticky abort flag.

## Operation
- Memory: 2^ADDR_W × 16 register array.
  - Combinational read.
  - The write is performed on the edge when `wr_en`=1 and `busy`=0. When `busy`=1, `wr_en` is ignored.
  - Reset does not clear the memory.
- Opcode is `DIN[15:13]` of the instruction word. Opcode 3'b001 (mvi) is a two-word instruction; the immediate is at `pc+1`. All other opcodes are one word.
- States:
  - IDLE: `Run`=0, `DIN`=0.
    - `start`=1 → ISSUE, with `pc`=0, `instr_count`=0, and `last_addr` latched.
  - ISSUE: `Run`=1, `DIN`=mem[pc]. This state lasts exactly one cycle (the processor's fetch step).
    - If the opcode is mvi and `pc`==latched `last_addr` (immediate missing) → ERR.
    - Otherwise → EXEC, with the EXEC cycle counter cleared.
  - EXEC: `Run`=1.
    - `DIN`=mem[pc+1] if the opcode is mvi, otherwise mem[pc].
    - On an edge with `Done`=1:
      - `instr_count` increments.
      - `next` = `pc` + (mvi ? 2 : 1), computed ADDR_W+1 bits wide.
      - If `next` > latched `last_addr` → IDLE. Otherwise → ISSUE with `pc`=`next`.
    - On an edge with `Done`=0, the cycle counter increments. If the counter reaches `TIMEOUT` → ERR.
  - ERR: `Run`=0, `DIN`=0, `error`=1.
    - `start`=1 → clears `error` and goes to ISSUE as from IDLE.
- `Run` stays high continuously across consecutive instructions. The processor returns to its step 0 on the cycle after `Done`.
- `Done` is ignored in IDLE, ISSUE and ERR.
- `start` is ignored while `busy`=1.
- The ADDR_W+1-bit comparison prevents wrap-around: with `last_addr`=2^ADDR_W−1, the program ends after the top word and never re-executes address 0.

## Timing
- Reset: `Resetn`=0 at an edge → IDLE on the next cycle from any state, aborting any instruction in flight. Outputs after reset:
  - `Run`=0, `DIN`=0, `busy`=0.
  - `pc`=0, `instr_count`=0, `error`=0.
- Start latency: `start` seen at edge N → `Run`=1 and `DIN`=mem[0] during cycle N+1.
- Per-instruction cycles, matching the processor:
  - mv: 2 (ISSUE + 1 EXEC).
  - mvi: 2, with the immediate on `DIN` during the EXEC cycle.
  - ALU ops: 4 (ISSUE + 3 EXEC).
- After the final `Done`, `Run` is 0 in the following cycle.
- `wr_en` in the same cycle as an accepted `start`: the write takes effect. Execution reads mem[0] combinationally in the next cycle.

## Test plan
- **mv program:** load mem[0]=16'h0400 (mv R0,R1) and mem[1]=16'h0880; `last_addr`=1; pulse `start`; processor model returns `Done` in step 1 → `DIN` sequence is 0400, 0400, 0880, 0880; `Run` is high for 4 cycles; `instr_count`=2; ends in IDLE with `busy`=0.
- **mvi immediate:** mem[0]=16'h2000 (mvi R0), mem[1]=16'h00A5, `last_addr`=1 → `DIN`=2000 in ISSUE, then 00A5 in EXEC; after `Done`, IDLE; `instr_count`=1.
- **ALU instruction:** mem[0]=16'h4000 (add), `Done` asserted on the 3rd EXEC cycle → `Run` high for exactly 4 cycles, `DIN` held at 4000 throughout; `pc` stays 0.
- **Boundary:** mvi at `pc`==`last_addr`=3 → ERR after ISSUE, `error`=1, `Run`=0. With `ADDR_W`=5, `last_addr`=31 and a full program, execution stops after address 31 with `instr_count`=32 and no re-fetch of address 0.
- **Timeout:** `Done` tied to 0 → ERR `TIMEOUT`=7 cycles after ISSUE; `error` stays 1 until `start`, which clears it and restarts at `pc`=0.
- **Reset and writes mid-run:** `Resetn`=0 during the 2nd EXEC cycle of an add → next cycle all outputs at their reset values and memory intact. `wr_en`=1 while `busy`=1 → memory unchanged, verified by re-running the program.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer for the processor's instruction side: a small program memory that
// presents instruction/immediate words on DIN and runs the Run/Done handshake.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              Done,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]      OP_MVI = 3'b001;
  localparam logic [ADDR_W:0] STEP1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] STEP2  = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_EXEC,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] last_q;
  logic [7:0]        cnt_q;
  logic [CW-1:0]     tmo_q;
  logic              run_q;
  logic              err_q;

  logic [15:0]       cur_w;
  logic [15:0]       imm_w;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_mvi;
  logic [ADDR_W:0]   next_d;
  logic [CW-1:0]     tmo_d;

  assign cur_w  = mem_q[pc_q];
  assign pc_inc = pc_q + 1'b1;
  assign imm_w  = mem_q[pc_inc];
  assign is_mvi = (cur_w[15:13] == OP_MVI);
  // One extra bit so a program ending at the top address cannot wrap back to 0.
  assign next_d = {1'b0, pc_q} + (is_mvi ? STEP2 : STEP1);
  assign tmo_d  = tmo_q + 1'b1;

  // Writes are locked out while a program runs, so mem[pc] is stable during EXEC.
  always_ff @(posedge Clock) begin
    if (wr_en && !run_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_q <= S_ISSUE;
            pc_q    <= '0;
            cnt_q   <= '0;
            last_q  <= last_addr;
            err_q   <= 1'b0;
            run_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (is_mvi && (pc_q == last_q)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            run_q   <= 1'b0;
          end else begin
            state_q <= S_EXEC;
            tmo_q   <= '0;
          end
        end
        S_EXEC: begin
          if (Done) begin
            cnt_q <= cnt_q + 8'd1;
            if (next_d > {1'b0, last_q}) begin
              state_q <= S_IDLE;
              run_q   <= 1'b0;
            end else begin
              state_q <= S_ISSUE;
              pc_q    <= next_d[ADDR_W-1:0];
            end
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == CW'(TIMEOUT)) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              run_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    DIN = '0;
    if (state_q == S_ISSUE) begin
      DIN = cur_w;
    end else if (state_q == S_EXEC) begin
      DIN = is_mvi ? imm_w : cur_w;
    end
  end

  assign Run         = run_q;
  assign busy        = run_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign error       = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a program-level model expands each program into the expected
// per-cycle Run/DIN/pc trace and drives Done from it.
module tb_instr_sequencer;

  localparam int AW    = 5;
  localparam int TO    = 7;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          Resetn, start, wr_en, Done;
  logic [AW-1:0] last_addr, wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   DIN;
  logic          Run, busy, error;
  logic [AW-1:0] pc;
  logic [7:0]    instr_count;

  instr_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .last_addr(last_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .Done(Done),
    .DIN(DIN), .Run(Run), .busy(busy), .pc(pc), .instr_count(instr_count),
    .error(error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          run;
    logic [15:0]   din;
    logic [AW-1:0] pc;
    logic          done;
  } cyc_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] shadow [DEPTH];
  int          lat    [DEPTH];
  cyc_t        exp_q[$];
  int          exp_cnt;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_cyc(input logic [15:0] din, input int a, input logic done);
    cyc_t e;
    e.run  = 1'b1;
    e.din  = din;
    e.pc   = a[AW-1:0];
    e.done = done;
    exp_q.push_back(e);
  endtask

  // Walk the program instruction by instruction; a latency above TO means no Done in time.
  task automatic build(input logic [AW-1:0] last);
    int   a;
    int   nxt;
    logic mvi;
    logic [15:0] w;
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    a = 0;
    while (1) begin
      w   = shadow[a];
      mvi = (w[15:13] == 3'b001);
      push_cyc(w, a, 1'b0);
      if (mvi && a == int'(last)) begin
        exp_err = 1'b1;
        break;
      end
      for (int k = 1; k <= lat[a] && k <= TO; k++)
        push_cyc(mvi ? shadow[(a + 1) % DEPTH] : w, a, k == lat[a]);
      if (lat[a] > TO) begin
        exp_err = 1'b1;
        break;
      end
      exp_cnt = (exp_cnt + 1) % 256;
      nxt = a + (mvi ? 2 : 1);
      if (nxt > int'(last)) break;
      a = nxt;
    end
  endtask

  task automatic set_lat_default();
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = shadow[i];
      lat[i] = (w[15:13] == 3'b000 || w[15:13] == 3'b001) ? 1 : 3;
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge Clock);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    @(negedge Clock);
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic run_prog(input string tag, input logic [AW-1:0] last,
                          input bit do_wr, input int wa, input logic [15:0] wd);
    cyc_t e;
    if (do_wr) shadow[wa] = wd;
    build(last);
    @(negedge Clock);
    start = 1'b1; last_addr = last;
    if (do_wr) begin wr_en = 1'b1; wr_addr = wa[AW-1:0]; wr_data = wd; end
    @(negedge Clock);
    start = 1'b0; wr_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".Run"}, Run, e.run);
      chk({tag, ".busy"}, busy, e.run);
      chk({tag, ".DIN"}, DIN, e.din);
      chk({tag, ".pc"}, pc, e.pc);
      Done = e.done;
      @(negedge Clock);
    end
    Done = 1'b0;
    chk({tag, ".end_Run"}, Run, 1'b0);
    chk({tag, ".end_busy"}, busy, 1'b0);
    chk({tag, ".end_DIN"}, DIN, 16'h0);
    chk({tag, ".end_error"}, error, exp_err);
    chk({tag, ".end_count"}, instr_count, exp_cnt[7:0]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".Run"}, Run, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".DIN"}, DIN, 16'h0);
    chk({tag, ".pc"}, pc, '0);
    chk({tag, ".count"}, instr_count, 8'd0);
    chk({tag, ".error"}, error, 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    int          lst;
    logic        dpat [6];
    Resetn = 1'b0; start = 1'b0; wr_en = 1'b0; Done = 1'b0;
    last_addr = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin shadow[i] = 16'h0; lat[i] = 1; end
    repeat (2) @(negedge Clock);
    chk_reset_vals("reset");
    Resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr(i, 16'h0);

    // mv program
    wr(0, 16'h0400); wr(1, 16'h0880);
    set_lat_default();
    run_prog("mv", 5'd1, 1'b0, 0, 16'h0);

    // mvi with immediate
    wr(0, 16'h2000); wr(1, 16'h00A5);
    set_lat_default();
    run_prog("mvi", 5'd1, 1'b0, 0, 16'h0);

    // ALU op, Done on 3rd EXEC cycle
    wr(0, 16'h4000);
    set_lat_default();
    run_prog("alu", 5'd0, 1'b0, 0, 16'h0);

    // mvi at last address -> ERR
    wr(0, 16'h0400); wr(1, 16'h0400); wr(2, 16'h0400); wr(3, 16'h2000);
    set_lat_default();
    run_prog("mvi_last", 5'd3, 1'b0, 0, 16'h0);

    // full program up to the top address, no wrap
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      if (w[15:13] == 3'b001) w[15:13] = 3'b000;
      wr(i, w);
    end
    set_lat_default();
    run_prog("full", 5'd31, 1'b0, 0, 16'h0);
    chk("full.count32", instr_count, 8'd32);

    // timeout, sticky error, restart clears it
    wr(0, 16'h4000); wr(1, 16'h0880);
    set_lat_default();
    lat[0] = 99;
    run_prog("timeout", 5'd0, 1'b0, 0, 16'h0);
    repeat (3) begin
      Done = 1'b1;
      @(negedge Clock);
      chk("timeout.sticky_err", error, 1'b1);
      chk("timeout.sticky_Run", Run, 1'b0);
    end
    Done = 1'b0;
    lat[0] = 3;
    run_prog("restart", 5'd1, 1'b0, 0, 16'h0);

    // reset during 2nd EXEC cycle of an add
    wr(0, 16'h0400); wr(1, 16'h0880); wr(2, 16'h4000);
    set_lat_default();
    dpat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge Clock); start = 1'b1; last_addr = 5'd2;
    @(negedge Clock); start = 1'b0;
    for (int i = 0; i < 6; i++) begin Done = dpat[i]; @(negedge Clock); end
    Done = 1'b0;
    chk("midrst.pre_Run", Run, 1'b1);
    chk("midrst.pre_pc", pc, 5'd2);
    chk("midrst.pre_count", instr_count, 8'd2);
    Resetn = 1'b0;
    @(negedge Clock);
    chk_reset_vals("midrst");
    Resetn = 1'b1;
    run_prog("after_rst", 5'd2, 1'b0, 0, 16'h0);

    // writes while busy are ignored
    @(negedge Clock); start = 1'b1; last_addr = 5'd2;
    @(negedge Clock); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = (i < 4); wr_addr = 5'(i % 3); wr_data = 16'hFFFF;
      Done = dpat[i];
      @(negedge Clock);
    end
    wr_en = 1'b0; Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    chk("busy_wr.idle", busy, 1'b0);
    run_prog("busy_wr", 5'd2, 1'b0, 0, 16'h0);

    // write in the same cycle as an accepted start
    lat[0] = 1;
    run_prog("wr_start", 5'd0, 1'b1, 0, 16'h0880);

    // randomized programs
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wr(i, 16'($urandom));
        lat[i] = ($urandom_range(0, 19) == 0) ? TO + 1 : int'($urandom_range(1, TO));
      end
      lst = int'($urandom_range(0, DEPTH - 1));
      run_prog($sformatf("rand%0d", t), lst[AW-1:0], 1'b0, 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
